// File: rtl/zigbee_chip_spreader.sv
// 802.15.4 DSSS spreader: bytes in, 32 chips per nibble out (low nibble first), one chip per chip_clk rise.
// First chip on the first tick >=2 cycles after accept; data_ready drops while the one-byte hold is occupied.
module zigbee_chip_spreader #(
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic       clock_in,
    input  logic       reset,
    input  logic       chip_clk,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    input  logic       data_last,
    output logic       data_ready,
    output logic       chip_out,
    output logic       chip_valid,
    output logic       symbol_start,
    output logic       frame_done,
    output logic       underrun,
    output logic       busy
);

    localparam logic [31:0] SEQ0     = 32'hD9C3522E;
    localparam logic [31:0] ODD_MASK = 32'h55555555;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state_q;
    logic        chip_clk_q;
    logic [7:0]  hold_dat_q;
    logic        hold_last_q;
    logic        hold_full_q;
    logic        hold_full_d;
    logic [7:0]  shift_q;
    logic        cur_last_q;
    logic        nibble_q;
    logic [4:0]  chip_idx_q;
    logic        chip_out_q;
    logic        chip_valid_q;
    logic        symbol_start_q;
    logic        frame_done_q;
    logic        underrun_q;

    logic        tick;
    logic        load;
    logic        unload;
    logic        byte_end;
    logic [3:0]  cur_sym;
    logic [31:0] cur_word;

    // seq(k) is seq(0) rotated right by 4*k; the upper eight symbols also invert odd chips.
    function automatic logic [31:0] chip_seq(input logic [3:0] sym);
        logic [63:0] rot;
        rot      = {SEQ0, SEQ0} >> {sym[2:0], 2'b00};
        chip_seq = rot[31:0] ^ (sym[3] ? ODD_MASK : 32'h0);
    endfunction

    assign tick     = chip_clk & ~chip_clk_q;
    assign load     = data_valid & ~hold_full_q;
    assign byte_end = (state_q == SEND) & tick & (chip_idx_q == 5'd31) & nibble_q;
    assign unload   = hold_full_q & (((state_q == IDLE)) | (byte_end & ~cur_last_q));
    assign cur_sym  = nibble_q ? shift_q[7:4] : shift_q[3:0];
    assign cur_word = chip_seq(cur_sym);

    assign hold_full_d = load | (hold_full_q & ~unload);

    always_ff @(posedge clock_in or negedge reset) begin
        if (!reset) begin
            hold_full_q <= 1'b0;
            hold_dat_q  <= 8'h00;
            hold_last_q <= 1'b0;
        end else begin
            hold_full_q <= hold_full_d;
            if (load) begin
                hold_dat_q  <= data_in;
                hold_last_q <= data_last;
            end
        end
    end

    always_ff @(posedge clock_in or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            chip_clk_q     <= 1'b0;
            shift_q        <= 8'h00;
            cur_last_q     <= 1'b0;
            nibble_q       <= 1'b0;
            chip_idx_q     <= 5'd0;
            chip_out_q     <= IDLE_LEVEL;
            chip_valid_q   <= 1'b0;
            symbol_start_q <= 1'b0;
            frame_done_q   <= 1'b0;
            underrun_q     <= 1'b0;
        end else begin
            chip_clk_q     <= chip_clk;
            symbol_start_q <= 1'b0;
            frame_done_q   <= 1'b0;
            underrun_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (hold_full_q) begin
                        shift_q    <= hold_dat_q;
                        cur_last_q <= hold_last_q;
                        nibble_q   <= 1'b0;
                        chip_idx_q <= 5'd0;
                        state_q    <= SEND;
                    end
                end
                SEND: begin
                    if (tick) begin
                        chip_out_q     <= cur_word[5'd31 - chip_idx_q];
                        chip_valid_q   <= 1'b1;
                        chip_idx_q     <= chip_idx_q + 5'd1;
                        symbol_start_q <= (chip_idx_q == 5'd0);
                        if (chip_idx_q == 5'd31) begin
                            if (!nibble_q) begin
                                nibble_q <= 1'b1;
                            end else if (cur_last_q) begin
                                state_q <= DRAIN;
                            end else if (hold_full_q) begin
                                // Back-to-back byte: reload without an idle chip in between.
                                shift_q    <= hold_dat_q;
                                cur_last_q <= hold_last_q;
                                nibble_q   <= 1'b0;
                            end else begin
                                underrun_q <= 1'b1;
                                state_q    <= DRAIN;
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (tick) begin
                        chip_out_q   <= IDLE_LEVEL;
                        chip_valid_q <= 1'b0;
                        frame_done_q <= 1'b1;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign data_ready   = ~hold_full_q;
    assign chip_out     = chip_out_q;
    assign chip_valid   = chip_valid_q;
    assign symbol_start = symbol_start_q;
    assign frame_done   = frame_done_q;
    assign underrun     = underrun_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_zigbee_chip_spreader.sv
// Bench for zigbee_chip_spreader: directed and random frames checked tick by tick against a chip-stream model.
module tb_zigbee_chip_spreader;

    logic       clock_in = 1'b0;
    logic       reset    = 1'b0;
    logic       chip_clk = 1'b0;
    logic [7:0] data_in  = 8'h00;
    logic       data_valid = 1'b0;
    logic       data_last  = 1'b0;
    logic       data_ready, chip_out, chip_valid, symbol_start, frame_done, underrun, busy;

    int checks = 0;
    int errors = 0;

    zigbee_chip_spreader #(.IDLE_LEVEL(1'b0)) dut (
        .clock_in     (clock_in),
        .reset        (reset),
        .chip_clk     (chip_clk),
        .data_in      (data_in),
        .data_valid   (data_valid),
        .data_last    (data_last),
        .data_ready   (data_ready),
        .chip_out     (chip_out),
        .chip_valid   (chip_valid),
        .symbol_start (symbol_start),
        .frame_done   (frame_done),
        .underrun     (underrun),
        .busy         (busy)
    );

    always #5 clock_in = ~clock_in;

    // Chip-clock divider (/50); freeze holds it low.
    bit freeze = 1'b0;
    int div_cnt = 0;
    always @(posedge clock_in) begin
        if (freeze) begin
            chip_clk <= 1'b0;
        end else begin
            div_cnt  <= (div_cnt == 49) ? 0 : div_cnt + 1;
            chip_clk <= (div_cnt < 25);
        end
    end

    int   cyc = 0;
    logic cc_prev, tick_seen;
    always @(posedge clock_in) cyc <= cyc + 1;
    always @(posedge clock_in or negedge reset) begin
        if (!reset) begin
            cc_prev   <= 1'b0;
            tick_seen <= 1'b0;
        end else begin
            tick_seen <= chip_clk & ~cc_prev;
            cc_prev   <= chip_clk;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] seq_ref(input int k);
        logic [31:0] base;
        logic [31:0] r;
        base = 32'hD9C3522E;
        for (int i = 0; i < 32; i++) r[i] = base[(i + 4 * (k % 8)) % 32];
        if (k >= 8) r = r ^ 32'h55555555;
        return r;
    endfunction

    typedef struct {
        logic [7:0] d;
        bit         l;
        int         acc;
    } byte_t;
    byte_t bq[$];

    byte_t cur;
    int    pos = 0;
    bit    in_frame = 0;
    bit    draining = 0;
    int    last_drain = -10;
    int    bytes_started = 0, chips_cnt = 0, fd_cnt = 0, ur_cnt = 0, ss_cnt = 0, ticks_cnt = 0;
    logic  prev_cv = 1'b0, prev_co = 1'b0;

    // Reference model: each accepted byte becomes seq(lo) then seq(hi); frames end on last or on an empty hold.
    always @(negedge clock_in) begin
        logic [4:0]  obs, exp;
        logic [31:0] w;
        int          e;
        obs = {chip_valid, chip_out, symbol_start, frame_done, underrun};
        if (!reset) begin
            chk("reset_outputs", {obs, data_ready, busy}, 7'b00000_1_0);
            bq.delete();
            in_frame   = 0;
            draining   = 0;
            pos        = 0;
            last_drain = -10;
            prev_cv    = 1'b0;
            prev_co    = 1'b0;
        end else begin
            if (tick_seen) begin
                ticks_cnt++;
                e   = cyc;
                exp = 5'b00000;
                if (draining) begin
                    exp        = 5'b00010;
                    draining   = 0;
                    in_frame   = 0;
                    last_drain = e;
                end else begin
                    if (!in_frame && bq.size() > 0 && e >= bq[0].acc + 2 && e >= last_drain + 2) begin
                        cur = bq.pop_front();
                        pos = 0;
                        in_frame = 1;
                        bytes_started++;
                    end
                    if (in_frame) begin
                        w   = seq_ref(pos < 32 ? int'(cur.d[3:0]) : int'(cur.d[7:4]));
                        exp = {1'b1, w[31 - (pos % 32)], (pos % 32) == 0, 1'b0, 1'b0};
                        if (pos == 63) begin
                            if (cur.l) begin
                                draining = 1;
                            end else if (bq.size() > 0 && bq[0].acc < e) begin
                                cur = bq.pop_front();
                                pos = 0;
                                bytes_started++;
                            end else begin
                                exp[0]   = 1'b1;
                                draining = 1;
                            end
                        end else begin
                            pos++;
                        end
                    end
                end
                chk("chip_tick", {27'd0, obs}, {27'd0, exp});
                if (chip_valid) chips_cnt++;
                if (frame_done) fd_cnt++;
                if (underrun) ur_cnt++;
                if (symbol_start) ss_cnt++;
            end else begin
                chk("no_tick_hold", {27'd0, obs}, {27'd0, prev_cv, prev_co, 3'b000});
            end
            prev_cv = chip_valid;
            prev_co = chip_out;
        end
    end

    task automatic step();
        @(negedge clock_in);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input bit l);
        byte_t b;
        int    n;
        n = 0;
        @(negedge clock_in);
        data_in    = d;
        data_last  = l;
        data_valid = 1'b1;
        while (!data_ready && n < 8000) begin
            @(negedge clock_in);
            n++;
        end
        chk("accept_timeout", {31'd0, data_ready}, 32'd1);
        if (data_ready) begin
            b.d   = d;
            b.l   = l;
            b.acc = cyc + 1;
            bq.push_back(b);
        end
        @(negedge clock_in);
        data_valid = 1'b0;
        #1;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 20000 && !(bq.size() == 0 && !in_frame && !busy); i++) step();
        chk("frame_finish", {31'd0, (bq.size() == 0 && !in_frame && !busy)}, 32'd1);
    endtask

    task automatic wait_pos(input int p, input int bs);
        for (int i = 0; i < 8000 && !(in_frame && pos == p && bytes_started == bs); i++) step();
        chk("reach_pos", {31'd0, (in_frame && pos == p && bytes_started == bs)}, 32'd1);
    endtask

    initial begin
        int c0, f0, u0, s0, t0, b0;
        int n;
        logic [7:0] d;

        repeat (4) @(negedge clock_in);
        #1;
        chk("rst_chip_out", {31'd0, chip_out}, 32'd0);
        chk("rst_ready", {31'd0, data_ready}, 32'd1);
        @(negedge clock_in);
        reset = 1'b1;

        // Idle for 200 ticks.
        t0 = ticks_cnt;
        for (int i = 0; i < 12000 && ticks_cnt < t0 + 200; i++) step();
        chk("idle_ticks", ticks_cnt - t0, 200);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_chips", chips_cnt, 0);

        // Single byte 8'h00.
        c0 = chips_cnt; f0 = fd_cnt; u0 = ur_cnt; s0 = ss_cnt;
        send_byte(8'h00, 1'b1);
        wait_pos(10, bytes_started + 1);
        chk("busy_mid_frame", {31'd0, busy}, 32'd1);
        wait_done();
        chk("b00_chips", chips_cnt - c0, 64);
        chk("b00_symstart", ss_cnt - s0, 2);
        chk("b00_done", fd_cnt - f0, 1);
        chk("b00_underrun", ur_cnt - u0, 0);

        // Single byte 8'h81.
        c0 = chips_cnt; f0 = fd_cnt; u0 = ur_cnt;
        send_byte(8'h81, 1'b1);
        wait_done();
        chk("b81_chips", chips_cnt - c0, 64);
        chk("b81_underrun", ur_cnt - u0, 0);

        // Two back-to-back bytes, second offered while the first is on air.
        c0 = chips_cnt; f0 = fd_cnt; u0 = ur_cnt; b0 = bytes_started;
        send_byte(8'h10, 1'b0);
        wait_pos(5, b0 + 1);
        send_byte(8'hF7, 1'b1);
        chk("b2b_ready_after_accept", {31'd0, data_ready}, 32'd0);
        wait_pos(63, b0 + 1);
        chk("b2b_ready_before_boundary", {31'd0, data_ready}, 32'd0);
        wait_pos(0, b0 + 2);
        chk("b2b_ready_after_boundary", {31'd0, data_ready}, 32'd1);
        wait_done();
        chk("b2b_chips", chips_cnt - c0, 128);
        chk("b2b_done", fd_cnt - f0, 1);
        chk("b2b_underrun", ur_cnt - u0, 0);

        // Underrun: no last, nothing follows.
        c0 = chips_cnt; f0 = fd_cnt; u0 = ur_cnt;
        send_byte(8'h22, 1'b0);
        wait_done();
        chk("ur_chips", chips_cnt - c0, 64);
        chk("ur_pulse", ur_cnt - u0, 1);
        chk("ur_done", fd_cnt - f0, 1);

        // Reset mid-chip, then a fresh frame.
        send_byte(8'h00, 1'b1);
        wait_pos(17, bytes_started + 1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_valid", {31'd0, chip_valid}, 32'd0);
        chk("async_rst_busy", {31'd0, busy}, 32'd0);
        chk("async_rst_ready", {31'd0, data_ready}, 32'd1);
        repeat (3) @(negedge clock_in);
        reset = 1'b1;
        c0 = chips_cnt; f0 = fd_cnt;
        send_byte(8'h00, 1'b1);
        wait_done();
        chk("post_rst_chips", chips_cnt - c0, 64);
        chk("post_rst_done", fd_cnt - f0, 1);

        // Chip clock stalled mid-frame.
        c0 = chips_cnt;
        send_byte(8'hA5, 1'b1);
        wait_pos(20, bytes_started + 1);
        freeze = 1'b1;
        n = chips_cnt;
        repeat (500) @(negedge clock_in);
        #1;
        chk("freeze_no_chips", chips_cnt, n);
        chk("freeze_busy", {31'd0, busy}, 32'd1);
        freeze = 1'b0;
        wait_done();
        chk("freeze_total_chips", chips_cnt - c0, 64);

        // Random frames with occasional late bytes.
        for (int f = 0; f < 3; f++) begin
            n = $urandom_range(1, 2);
            for (int b = 0; b < n; b++) begin
                d = 8'($urandom);
                send_byte(d, b == n - 1);
                if (b < n - 1 && $urandom_range(0, 3) == 0) repeat (3300) @(negedge clock_in);
            end
            wait_done();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
